hazard_unit: RTL and testbench

Pipeline hazard controller for the five-stage MIPS core. Forwarding resolves what it can; this block handles what forwarding cannot. It detects load-use, branch-operand, instruction-fetch and data-memory-wait hazards, plus halt. For each case it drives per-stage pipeline-register enables and flushes. It sits beside the forwarding unit, reads the same per-stage instruction words, and owns the PC enable and halt state.

---
 rtl/hazard_unit_if.sv | 71 +++++++
 rtl/hazard_unit.sv | 193 +++++++++++++++++++
 tb/tb_hazard_unit.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_unit_if.sv
// -----------------------------------------------------------------------------
// hazard_unit_if
//   Bundle of the signals exchanged between the pipeline datapath and the
//   hazard unit.
//
//   master : pipeline side. Drives the per-stage status and instruction
//            words, and receives the enables, flushes, halt and stall count.
//   slave  : hazard unit side. The mirror image of master.
//
//   Signals driven by the pipeline:
//     ihit, dhit              icache / dcache completion strobes
//     dec_reg, ex_reg         instruction words in decode / execute
//     ex_dest, mem_dest       destination registers of the EX / MEM instruction
//     ex_rfWEN, mem_rfWEN     EX / MEM instruction writes the register file
//     ex_dREN                 load in EX
//     mem_dREN, mem_dWEN      load / store in MEM
//     br_taken                decode-stage branch or jump resolved taken
//     wb_halt                 HALT opcode in the MEM/WB register
//   Signals driven by the hazard unit:
//     pc_en, *_en             PC and pipeline register enables
//     *_flush                 load a bubble into that register on the next edge
//     halt                    latched halt
//     stall_cnt               saturating count of stalled cycles
// -----------------------------------------------------------------------------
interface hazard_unit_if #(
    parameter int ST_W = 16
);
    logic            ihit;
    logic            dhit;
    logic [31:0]     dec_reg;
    logic [31:0]     ex_reg;
    logic [4:0]      ex_dest;
    logic [4:0]      mem_dest;
    logic            ex_rfWEN;
    logic            mem_rfWEN;
    logic            ex_dREN;
    logic            mem_dREN;
    logic            mem_dWEN;
    logic            br_taken;
    logic            wb_halt;

    logic            pc_en;
    logic            ifid_en;
    logic            idex_en;
    logic            exmem_en;
    logic            memwb_en;
    logic            ifid_flush;
    logic            idex_flush;
    logic            exmem_flush;
    logic            memwb_flush;
    logic            halt;
    logic [ST_W-1:0] stall_cnt;

    modport master (
        output ihit, dhit, dec_reg, ex_reg, ex_dest, mem_dest,
               ex_rfWEN, mem_rfWEN, ex_dREN, mem_dREN, mem_dWEN,
               br_taken, wb_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt
    );

    modport slave (
        input  ihit, dhit, dec_reg, ex_reg, ex_dest, mem_dest,
               ex_rfWEN, mem_rfWEN, ex_dREN, mem_dREN, mem_dWEN,
               br_taken, wb_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               halt, stall_cnt
    );
endinterface

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Pipeline hazard controller for the five-stage MIPS core. Resolves the
//   hazards forwarding cannot: load-use, branch operands produced in EX or
//   loaded in MEM, icache miss, dcache wait, and HALT. Drives the PC enable,
//   the four pipeline-register enables and flushes, the latched halt and a
//   saturating stall counter.
//
//   Ports:
//     CLK   in   core clock, all state updates on the rising edge
//     nRST  in   synchronous active-low reset
//     bus   slave modport of hazard_unit_if (all hazard inputs and outputs)
//
//   Enables and flushes are combinational from the inputs and the FSM state;
//   halt and stall_cnt are registered.
// -----------------------------------------------------------------------------
module hazard_unit #(
    parameter int ST_W = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    hazard_unit_if.slave  bus
);

    // MIPS primary opcodes that matter for source-register usage.
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_SC    = 6'b111000;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // LDBR holds the second bubble owed to a branch whose operand is a load
    // still in EX; HALTED is absorbing until reset.
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LDBR   = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic            halt_q;
    logic [ST_W-1:0] stall_cnt_q, stall_cnt_d;

    // ------------------------------------------------------------------
    // Decode-stage source usage
    // ------------------------------------------------------------------
    logic [5:0] dec_op;
    logic [4:0] dec_rs, dec_rt;
    logic       rs_used, rt_used;

    assign dec_op = bus.dec_reg[31:26];
    assign dec_rs = bus.dec_reg[25:21];
    assign dec_rt = bus.dec_reg[20:16];

    assign rs_used = !(dec_op inside {OP_J, OP_JAL, OP_LUI, OP_HALT});
    assign rt_used =   dec_op inside {OP_RTYPE, OP_BEQ, OP_BNE, OP_SW, OP_SC};

    // ------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------
    logic lu_hz, br_dec, bx_hz, bm_hz, data_hz, dwait;

    // Register $0 is hardwired to zero, so a zero destination never stalls.
    assign lu_hz = bus.ex_dREN && (bus.ex_dest != 5'd0) &&
                   ((rs_used && (bus.ex_dest == dec_rs)) ||
                    (rt_used && (bus.ex_dest == dec_rt)));

    // Branches compare in decode, so they also wait on ALU results in EX and
    // on loads still in MEM, which forwarding cannot reach in time.
    assign br_dec = (dec_op == OP_BEQ) || (dec_op == OP_BNE);

    assign bx_hz = br_dec && bus.ex_rfWEN && (bus.ex_dest != 5'd0) &&
                   ((bus.ex_dest == dec_rs) || (bus.ex_dest == dec_rt));

    assign bm_hz = br_dec && bus.mem_dREN && (bus.mem_dest != 5'd0) &&
                   ((bus.mem_dest == dec_rs) || (bus.mem_dest == dec_rt));

    assign data_hz = lu_hz || bx_hz || bm_hz;

    assign dwait = (bus.mem_dREN || bus.mem_dWEN) && !bus.dhit;

    // The following inputs carry no information this block needs; they are
    // part of the shared per-stage view used alongside the forwarding unit.
    logic unused_inputs;
    assign unused_inputs = ^{bus.ex_reg, bus.dec_reg[15:0], bus.mem_rfWEN};

    // ------------------------------------------------------------------
    // Enable / flush generation and next state, in priority order
    // ------------------------------------------------------------------
    logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic ifid_flush, idex_flush, exmem_flush, memwb_flush;

    always_comb begin
        // NOTE: every signal gets a default before the priority chain so no
        // path through the if/else leaves one unassigned and infers a latch.
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        state_d     = state_q;

        if (!nRST) begin
            // Bubbles everywhere; the flushed registers also take their own
            // reset on this edge, so the enables stay low.
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b1111;
            state_d = RUN;
        end else if (state_q == HALTED) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
        end else if (bus.wb_halt) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b0;
            state_d = HALTED;
        end else if (dwait) begin
            // Freeze everything up to EX/MEM; let WB drain and refill MEM/WB
            // with a bubble until the dcache answers. LDBR is held so its
            // second bubble is still delivered once the wait clears.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_en     = 1'b0;
            exmem_en    = 1'b0;
            memwb_flush = 1'b1;
        end else if (state_q == LDBR) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = RUN;
        end else if (data_hz) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            // A load feeding a branch needs the value through MEM before the
            // decode-stage compare can use it: one extra bubble.
            if (bx_hz && bus.ex_dREN) begin
                state_d = LDBR;
            end
        end else if (!bus.ihit) begin
            pc_en      = 1'b0;
            ifid_flush = 1'b1;
        end else if (bus.br_taken) begin
            ifid_flush = 1'b1;
        end
    end

    // Counts every cycle the PC is held while the core is live.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_en && (state_q != HALTED) && (stall_cnt_q != {ST_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        // NOTE: non-blocking assignments so every register samples the
        // pre-edge values regardless of statement order.
        if (!nRST) begin
            state_q     <= RUN;
            halt_q      <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            halt_q      <= (state_d == HALTED);
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.memwb_flush = memwb_flush;
    assign bus.halt        = halt_q;
    assign bus.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Directed test of hazard_unit with a 4-bit stall counter so saturation is
//   reachable quickly. Inputs change 1 time unit after the rising edge and
//   outputs are checked 1 time unit later, well clear of the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

    localparam int ST_W = 4;

    // Control vector order:
    // {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    //  ifid_flush, idex_flush, exmem_flush, memwb_flush}
    localparam logic [8:0] C_RUN   = 9'b11111_0000;
    localparam logic [8:0] C_STALL = 9'b00111_0100;
    localparam logic [8:0] C_DWAIT = 9'b00001_0001;
    localparam logic [8:0] C_IMISS = 9'b01111_1000;
    localparam logic [8:0] C_BRT   = 9'b11111_1000;
    localparam logic [8:0] C_FROZE = 9'b00000_0000;
    localparam logic [8:0] C_RST   = 9'b00000_1111;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    logic clk;
    logic nrst;
    int   n_checks;
    int   n_fail;

    hazard_unit_if #(.ST_W(ST_W)) hif ();

    hazard_unit #(.ST_W(ST_W)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [8:0] ctrl;
    assign ctrl = {hif.pc_en, hif.ifid_en, hif.idex_en, hif.exmem_en, hif.memwb_en,
                   hif.ifid_flush, hif.idex_flush, hif.exmem_flush, hif.memwb_flush};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
        return {op, rs, rt, rd, 11'b0};
    endfunction

    // Quiet pipeline: NOP everywhere, caches hitting.
    task automatic idle();
        hif.ihit      = 1'b1;
        hif.dhit      = 1'b1;
        hif.dec_reg   = '0;
        hif.ex_reg    = '0;
        hif.ex_dest   = '0;
        hif.mem_dest  = '0;
        hif.ex_rfWEN  = 1'b0;
        hif.mem_rfWEN = 1'b0;
        hif.ex_dREN   = 1'b0;
        hif.mem_dREN  = 1'b0;
        hif.mem_dWEN  = 1'b0;
        hif.br_taken  = 1'b0;
        hif.wb_halt   = 1'b0;
    endtask

    // Advance one clock; inputs may be changed on return.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply the current inputs for one cycle under reset, then release.
    task automatic do_reset();
        nrst = 1'b0;
        idle();
        tick();
        nrst = 1'b1;
    endtask

    // A load to $5 in EX with a BEQ on $5 in decode.
    task automatic load_branch_inputs();
        idle();
        hif.ex_dREN  = 1'b1;
        hif.ex_rfWEN = 1'b1;
        hif.ex_dest  = 5'd5;
        hif.dec_reg  = enc(OP_BEQ, 5'd5, 5'd0, 5'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        nrst     = 1'b0;
        idle();

        // ---------------- reset ----------------
        #1;
        check("rst_ctrl", 32'(ctrl), 32'(C_RST));
        tick();
        nrst = 1'b1;
        #1;
        check("rst_run", 32'(ctrl), 32'(C_RUN));
        check("rst_halt", 32'(hif.halt), 32'd0);
        check("rst_cnt", 32'(hif.stall_cnt), 32'd0);

        // ---------------- load-use ----------------
        hif.ex_dREN = 1'b1;
        hif.ex_dest = 5'd2;
        hif.dec_reg = enc(OP_R, 5'd2, 5'd4, 5'd3);      // ADD $3,$2,$4
        #1;
        check("lu_stall", 32'(ctrl), 32'(C_STALL));
        tick();
        idle();
        hif.dec_reg = enc(OP_R, 5'd2, 5'd4, 5'd3);      // bubble now in EX
        #1;
        check("lu_resume", 32'(ctrl), 32'(C_RUN));
        check("lu_cnt", 32'(hif.stall_cnt), 32'd1);

        // rt of ADDI is a destination, LUI reads no rs, $0 never stalls
        hif.ex_dREN = 1'b1;
        hif.ex_dest = 5'd2;
        hif.dec_reg = enc(OP_ADDI, 5'd7, 5'd2, 5'd0);
        #1;
        check("lu_addi_rt", 32'(ctrl), 32'(C_RUN));
        hif.dec_reg = enc(OP_LUI, 5'd2, 5'd9, 5'd0);
        #1;
        check("lu_lui_rs", 32'(ctrl), 32'(C_RUN));
        hif.ex_dest = 5'd0;
        hif.dec_reg = enc(OP_R, 5'd0, 5'd0, 5'd3);
        #1;
        check("lu_zero", 32'(ctrl), 32'(C_RUN));
        hif.ex_dest = 5'd4;                              // rt of R-type
        hif.dec_reg = enc(OP_R, 5'd1, 5'd4, 5'd3);
        #1;
        check("lu_rt", 32'(ctrl), 32'(C_STALL));

        // ---------------- load-to-branch ----------------
        do_reset();
        load_branch_inputs();
        #1;
        check("lb_stall1", 32'(ctrl), 32'(C_STALL));
        tick();                                          // -> LDBR
        idle();
        hif.dec_reg  = enc(OP_BEQ, 5'd5, 5'd0, 5'd0);
        hif.mem_dREN = 1'b1;
        hif.mem_dest = 5'd5;
        #1;
        check("lb_stall2", 32'(ctrl), 32'(C_STALL));
        tick();                                          // -> RUN
        idle();
        hif.dec_reg = enc(OP_BEQ, 5'd5, 5'd0, 5'd0);
        #1;
        check("lb_resume", 32'(ctrl), 32'(C_RUN));
        check("lb_cnt", 32'(hif.stall_cnt), 32'd2);

        // ALU producer feeding a BNE: exactly one bubble
        hif.ex_rfWEN = 1'b1;
        hif.ex_dest  = 5'd6;
        hif.dec_reg  = enc(OP_BNE, 5'd1, 5'd6, 5'd0);
        #1;
        check("bx_alu", 32'(ctrl), 32'(C_STALL));
        tick();
        idle();
        hif.dec_reg   = enc(OP_BNE, 5'd1, 5'd6, 5'd0);
        hif.mem_rfWEN = 1'b1;
        hif.mem_dest  = 5'd6;
        #1;
        check("bx_alu_done", 32'(ctrl), 32'(C_RUN));
        check("bx_cnt", 32'(hif.stall_cnt), 32'd3);

        // BM: load in MEM feeding a branch (not entered via LDBR)
        idle();
        hif.mem_dREN = 1'b1;
        hif.mem_dest = 5'd8;
        hif.dec_reg  = enc(OP_BEQ, 5'd0, 5'd8, 5'd0);
        #1;
        check("bm_stall", 32'(ctrl), 32'(C_STALL));

        // ---------------- DWAIT on a store ----------------
        do_reset();
        hif.mem_dWEN = 1'b1;
        hif.dhit     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("dw_sw%0d", i), 32'(ctrl), 32'(C_DWAIT));
            tick();
        end
        hif.dhit = 1'b1;
        #1;
        check("dw_sw_done", 32'(ctrl), 32'(C_RUN));
        check("dw_sw_cnt", 32'(hif.stall_cnt), 32'd3);

        // ---------------- DWAIT overlapping LDBR ----------------
        do_reset();
        load_branch_inputs();
        #1;
        check("ov_stall1", 32'(ctrl), 32'(C_STALL));
        tick();                                          // -> LDBR
        idle();
        hif.dec_reg  = enc(OP_BEQ, 5'd5, 5'd0, 5'd0);
        hif.mem_dREN = 1'b1;
        hif.mem_dest = 5'd5;
        hif.dhit     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("ov_dwait%0d", i), 32'(ctrl), 32'(C_DWAIT));
            tick();
        end
        hif.dhit = 1'b1;
        #1;
        check("ov_bubble2", 32'(ctrl), 32'(C_STALL));
        tick();
        idle();
        hif.dec_reg = enc(OP_BEQ, 5'd5, 5'd0, 5'd0);
        #1;
        check("ov_resume", 32'(ctrl), 32'(C_RUN));
        check("ov_cnt", 32'(hif.stall_cnt), 32'd5);

        // ---------------- taken branch / icache miss ----------------
        do_reset();
        hif.br_taken = 1'b1;
        #1;
        check("brt_hit", 32'(ctrl), 32'(C_BRT));
        hif.ihit = 1'b0;
        #1;
        check("brt_miss", 32'(ctrl), 32'(C_IMISS));
        hif.br_taken = 1'b0;
        #1;
        check("imiss", 32'(ctrl), 32'(C_IMISS));

        // ---------------- reset mid-LDBR with stall_cnt=7 ----------------
        do_reset();
        hif.ihit = 1'b0;
        repeat (6) tick();
        load_branch_inputs();
        tick();                                          // -> LDBR, cnt 7
        idle();
        hif.dec_reg  = enc(OP_BEQ, 5'd5, 5'd0, 5'd0);
        hif.mem_dREN = 1'b1;
        hif.mem_dest = 5'd5;
        #1;
        check("mr_cnt7", 32'(hif.stall_cnt), 32'd7);
        check("mr_in_ldbr", 32'(ctrl), 32'(C_STALL));
        nrst = 1'b0;
        #1;
        check("mr_rst_ctrl", 32'(ctrl), 32'(C_RST));
        tick();
        nrst = 1'b1;
        idle();
        #1;
        check("mr_run", 32'(ctrl), 32'(C_RUN));
        check("mr_cnt0", 32'(hif.stall_cnt), 32'd0);
        check("mr_halt0", 32'(hif.halt), 32'd0);

        // ---------------- saturation ----------------
        hif.ihit = 1'b0;
        repeat (20) tick();
        check("sat_cnt", 32'(hif.stall_cnt), 32'd15);

        // ---------------- halt ----------------
        do_reset();
        hif.wb_halt = 1'b1;
        #1;
        check("halt_ctrl", 32'(ctrl), 32'(C_FROZE));
        check("halt_not_yet", 32'(hif.halt), 32'd0);
        tick();
        idle();
        hif.ihit = 1'b0;
        #1;
        check("halt_set", 32'(hif.halt), 32'd1);
        check("halt_frozen", 32'(ctrl), 32'(C_FROZE));
        check("halt_cnt", 32'(hif.stall_cnt), 32'd1);
        repeat (5) tick();
        check("halt_held", 32'(hif.halt), 32'd1);
        check("halt_cnt_held", 32'(hif.stall_cnt), 32'd1);
        do_reset();
        #1;
        check("halt_cleared", 32'(hif.halt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
